register_slice_skid: RTL and testbench

- Two-entry valid/ready register slice (skid buffer) for pipeline stages that need backpressure as well as forward data registration.
- Registers the forward path (m_valid, m_data) and the backward path (s_ready), so no combinational path runs from m_ready to s_ready or from s_valid/s_data to m_valid/m_data.
- Sits between PE-array pipeline stages and memory-interface stages wherever a plain synchronous data register cannot absorb stalls.

---
 rtl/register_slice_skid.sv | 87 ++++++++
 tb/tb_register_slice_skid.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/register_slice_skid.sv
// Two-entry valid/ready register slice with a skid register.
// All outputs come straight from flops, cutting both forward and backward timing paths.
module register_slice_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic             s_xfer;

  // s_data only matters when a real upstream transfer happens
  assign s_xfer = s_valid & s_ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (s_xfer) begin
          state_d = StOne;
          main_d  = s_data;
        end
      end
      StOne: begin
        if (s_xfer && !m_ready) begin
          state_d = StFull;
          skid_d  = s_data;
        end else if (!s_xfer && m_ready) begin
          state_d = StEmpty;
        end else if (s_xfer && m_ready) begin
          main_d = s_data;
        end
      end
      StFull: begin
        if (m_ready) begin
          state_d = StOne;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    s_ready_d = (state_d != StFull);
    m_valid_d = (state_d != StEmpty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StEmpty;
      main_q    <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = main_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_register_slice_skid.sv
// Bench for register_slice_skid: directed phases plus a queue-based scoreboard
// that tracks every accepted word through to the downstream port.
module tb_register_slice_skid;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] occupancy;

  register_slice_skid #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model, advanced at each falling edge to predict the next rising edge.
  logic [7:0] q[$];
  int         exp_occ    = 0;
  bit         exp_ready  = 1'b0;
  bit         known      = 1'b0;
  bit         zero_data  = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] prev_data;

  always @(negedge clk) begin
    bit acc, emit;
    if (known) begin
      chk("m_valid", int'(m_valid), int'(exp_occ != 0));
      chk("occupancy", int'(occupancy), exp_occ);
      chk("s_ready", int'(s_ready), int'(exp_ready));
      if (m_valid) begin
        if (q.size() == 0) chk("sb_nonempty", 0, 1);
        else chk("sb_order", int'(m_data), int'(q[0]));
      end
      if (zero_data) chk("m_data_after_reset", int'(m_data), 0);
      if (stall_prev) chk("stall_stable", int'(m_data), int'(prev_data));
    end
    stall_prev = known && !reset && m_valid && !m_ready;
    prev_data  = m_data;
    if (reset) begin
      q.delete();
      exp_occ   = 0;
      exp_ready = 1'b0;
      known     = 1'b1;
      zero_data = 1'b1;
    end else if (known) begin
      acc  = s_valid && exp_ready;
      emit = (exp_occ != 0) && m_ready;
      if (emit) void'(q.pop_front());
      if (acc) begin
        q.push_back(s_data);
        zero_data = 1'b0;
      end
      exp_occ   = exp_occ + int'(acc) - int'(emit);
      exp_ready = (exp_occ != 2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int cyc;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b1;

    // Reset, then back-to-back pass-through
    step();
    step();
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    reset = 1'b0;
    step();
    chk("s_ready_after_rst", int'(s_ready), 1);
    for (int i = 1; i <= 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      step();
      chk("pass_m_data", int'(m_data), i);
      chk("pass_m_valid", int'(m_valid), 1);
      chk("pass_occ", int'(occupancy), 1);
    end
    s_valid = 1'b0;
    step();
    chk("pass_drained", int'(occupancy), 0);

    // Backpressure fill
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h11;
    step();
    chk("bp_m_data_1", int'(m_data), 'h11);
    chk("bp_occ_1", int'(occupancy), 1);
    s_data = 8'h22;
    step();
    chk("bp_occ_2", int'(occupancy), 2);
    chk("bp_s_ready_0", int'(s_ready), 0);
    s_data = 8'h33;
    step();
    chk("bp_occ_hold", int'(occupancy), 2);
    chk("bp_m_data_hold", int'(m_data), 'h11);

    // Drain from FULL while 0x33 stays offered
    m_ready = 1'b1;
    step();
    chk("drain_m_data_22", int'(m_data), 'h22);
    chk("drain_s_ready", int'(s_ready), 1);
    chk("drain_occ", int'(occupancy), 1);
    step();
    chk("drain_m_data_33", int'(m_data), 'h33);
    chk("drain_m_valid", int'(m_valid), 1);
    s_valid = 1'b0;
    step();
    chk("drain_empty", int'(occupancy), 0);

    // Random stalls on both sides
    sent = 0;
    cyc  = 0;
    while (sent < 200 && cyc < 3000) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data  = 8'(sent * 7 + 3);
      if (s_valid && exp_ready) sent++;
      step();
      cyc++;
    end
    chk("rand_all_sent", sent, 200);
    s_valid = 1'b0;
    m_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 10) begin
      step();
      cyc++;
    end
    chk("rand_drained", q.size(), 0);
    step();

    // Reset while FULL
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    step();
    s_data = 8'hBB;
    step();
    chk("mid_full", int'(occupancy), 2);
    s_valid = 1'b0;
    reset   = 1'b1;
    step();
    chk("mid_m_valid", int'(m_valid), 0);
    chk("mid_occ", int'(occupancy), 0);
    chk("mid_m_data", int'(m_data), 0);
    reset   = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_leak", int'(m_valid), 0);
    end

    // Simultaneous in/out in ONE
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h40;
    step();
    chk("sim_m_data_40", int'(m_data), 'h40);
    s_data  = 8'h41;
    m_ready = 1'b1;
    step();
    chk("sim_m_data_41", int'(m_data), 'h41);
    chk("sim_occ", int'(occupancy), 1);
    s_valid = 1'b0;
    step();
    chk("sim_empty", int'(occupancy), 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
